// File: rtl/line_follow_pkg.sv
// Shared definitions for the line-follower steering controller:
// H-bridge direction codes, FSM state encoding and the 1 ms tick helper.
package line_follow_pkg;

    // H-bridge direction codes
    localparam logic [3:0] FWD   = 4'b1001;
    localparam logic [3:0] LEFT  = 4'b1010;
    localparam logic [3:0] RIGHT = 4'b0101;
    localparam logic [3:0] STOP  = 4'b0000;

    // Controller FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRACK  = 3'd1,
        SRCH_L = 3'd2,
        SRCH_R = 3'd3,
        LOST   = 3'd4
    } state_t;

    // Clock cycles per millisecond, never less than one
    function automatic int unsigned MS_TICK(input int unsigned clk_hz);
        return (clk_hz >= 1000) ? (clk_hz / 1000) : 1;
    endfunction

endpackage

// File: rtl/line_follow_ctrl_pwm_gen.sv
// PWM generator: period of 2^PWM_BITS-1 cycles, output high while cnt < duty.
// Duty is captured only at the start of a period so a mid-period change
// never produces a runt pulse; duty=0 gives constant low, all-ones constant high.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] eff_duty;

    // At cnt==0 the freshly sampled duty applies to the very first slot
    always_comb begin
        eff_duty = (cnt == '0) ? duty : duty_q;
    end

    // Free-running period counter, duty capture and registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            duty_q  <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
                duty_q <= duty;
            end
            pwm_out <= (cnt < eff_duty);
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower steering controller: synchronised active-low IPS sensors
// drive an H-bridge direction code, with a timed lost-path search
// (first sweep, second sweep, then stop) and PWM motor enables.
// Optional feature macro: SEARCH_LAST_SIDE_EN (first sweep toward the
// side the line was last seen on).
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int N_SENS    = 3,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SRCH_L_MS = 2000,
    parameter int SRCH_R_MS = 4000,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SENS-1:0]   IPS,
    input  logic                sw_ON,
    input  logic [PWM_BITS-1:0] speed,
    output logic [3:0]          IN,
    output logic [1:0]          EN,
    output logic                lost,
    output logic                searching
);

    localparam int CENTRE = N_SENS / 2;
    localparam int TICK   = int'(MS_TICK(CLK_HZ));
    localparam int PRE_W  = $clog2(TICK + 1);
    localparam int MS_MAX = (SRCH_L_MS > SRCH_R_MS) ? SRCH_L_MS : SRCH_R_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    logic [N_SENS-1:0] ips_s1, ips_s2;
    logic              sw_s1, sw_s2;
    logic [N_SENS-1:0] lit;
    logic              c_lit, l_lit, r_lit, any_lit;

    state_t            state, next_state;

    logic [PRE_W-1:0]  pre_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic              tick, timer_clr, l_done, r_done;

    logic [3:0]        in_d;
    logic              en_d, lost_d, srch_d;
    logic              en_q;
    logic              pwm;

`ifdef SEARCH_LAST_SIDE_EN
    logic              last_left, last_left_d;
    logic              sweep_2nd, sweep_2nd_d;
`endif

    // Two-flop synchronisers; sensors clear to "not detected" (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ips_s1 <= '1;
            ips_s2 <= '1;
            sw_s1  <= 1'b0;
            sw_s2  <= 1'b0;
        end else begin
            ips_s1 <= IPS;
            ips_s2 <= ips_s1;
            sw_s1  <= sw_ON;
            sw_s2  <= sw_s1;
        end
    end

    // Sensor decode: higher indices are left of centre
    always_comb begin
        lit     = ~ips_s2;
        c_lit   = lit[CENTRE];
        l_lit   = |lit[N_SENS-1:CENTRE+1];
        r_lit   = |lit[CENTRE-1:0];
        any_lit = |lit;
    end

    // Sweep completion: the ms that brings the timer to the sweep length
    always_comb begin
        tick      = (pre_cnt == PRE_W'(TICK - 1));
        l_done    = tick && (ms_cnt == MS_W'(SRCH_L_MS - 1));
        r_done    = tick && (ms_cnt == MS_W'(SRCH_R_MS - 1));
        timer_clr = (next_state != state) || !((state == SRCH_L) || (state == SRCH_R));
    end

    // Next-state logic; reacquiring the line always beats a timer expiry
    always_comb begin
        next_state = state;
`ifdef SEARCH_LAST_SIDE_EN
        last_left_d = last_left;
        sweep_2nd_d = sweep_2nd;
`endif
        if (!sw_s2) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:   next_state = TRACK;
                TRACK: begin
                    if (!any_lit) begin
`ifdef SEARCH_LAST_SIDE_EN
                        next_state = last_left ? SRCH_L : SRCH_R;
`else
                        next_state = SRCH_L;
`endif
                    end
                end
                SRCH_L: begin
                    if (any_lit) begin
                        next_state = TRACK;
`ifdef SEARCH_LAST_SIDE_EN
                    end else if (sweep_2nd ? r_done : l_done) begin
                        next_state = sweep_2nd ? LOST : SRCH_R;
`else
                    end else if (l_done) begin
                        next_state = SRCH_R;
`endif
                    end
                end
                SRCH_R: begin
                    if (any_lit) begin
                        next_state = TRACK;
`ifdef SEARCH_LAST_SIDE_EN
                    end else if (sweep_2nd ? r_done : l_done) begin
                        next_state = sweep_2nd ? LOST : SRCH_L;
`else
                    end else if (r_done) begin
                        next_state = LOST;
`endif
                    end
                end
                LOST: begin
                    if (any_lit) begin
                        next_state = TRACK;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
`ifdef SEARCH_LAST_SIDE_EN
        // Centre-only sightings leave the recorded side unchanged
        if ((state == TRACK) && !c_lit) begin
            if (l_lit) begin
                last_left_d = 1'b1;
            end else if (r_lit) begin
                last_left_d = 1'b0;
            end
        end
        // First sweep uses SRCH_L_MS, the one after a sweep-to-sweep hop SRCH_R_MS
        if ((next_state != SRCH_L) && (next_state != SRCH_R)) begin
            sweep_2nd_d = 1'b0;
        end else if ((next_state != state) && ((state == SRCH_L) || (state == SRCH_R))) begin
            sweep_2nd_d = 1'b1;
        end
`endif
    end

    // Output decode from the upcoming state so outputs register with it
    always_comb begin
        in_d   = STOP;
        en_d   = 1'b0;
        lost_d = 1'b0;
        srch_d = 1'b0;
        case (next_state)
            TRACK: begin
                en_d = 1'b1;
                if (c_lit) begin
                    in_d = FWD;
                end else if (l_lit) begin
                    in_d = LEFT;
                end else if (r_lit) begin
                    in_d = RIGHT;
                end
            end
            SRCH_L: begin
                in_d   = LEFT;
                en_d   = 1'b1;
                srch_d = 1'b1;
            end
            SRCH_R: begin
                in_d   = RIGHT;
                en_d   = 1'b1;
                srch_d = 1'b1;
            end
            LOST:    lost_d = 1'b1;
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            IN        <= STOP;
            en_q      <= 1'b0;
            lost      <= 1'b0;
            searching <= 1'b0;
        end else begin
            state     <= next_state;
            IN        <= in_d;
            en_q      <= en_d;
            lost      <= lost_d;
            searching <= srch_d;
        end
    end

`ifdef SEARCH_LAST_SIDE_EN
    // Last-seen side and sweep-order tracking; reset assumes left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_left <= 1'b1;
            sweep_2nd <= 1'b0;
        end else begin
            last_left <= last_left_d;
            sweep_2nd <= sweep_2nd_d;
        end
    end
`endif

    // ms prescaler and saturating ms counter, cleared outside a running sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (timer_clr) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick && (ms_cnt != MS_W'(MS_MAX))) begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (speed),
        .pwm_out (pwm)
    );

    assign EN = en_q ? {2{pwm}} : 2'b00;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl (1 ms = 1 cycle, sweeps 4/8 ms, 4-bit PWM).
// Expected outputs are queued when stimulus is driven and popped when sampled.
module tb_line_follow_ctrl;

    localparam logic [3:0] C_FWD   = 4'b1001;
    localparam logic [3:0] C_LEFT  = 4'b1010;
    localparam logic [3:0] C_RIGHT = 4'b0101;
    localparam logic [3:0] C_STOP  = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] IPS;
    logic       sw_ON;
    logic [3:0] speed;
    logic [3:0] IN;
    logic [1:0] EN;
    logic       lost;
    logic       searching;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [3:0] in_v;
        bit         chk_en;
        logic [1:0] en_v;
        logic       lost_v;
        logic       srch_v;
    } exp_t;

    exp_t sbq[$];

    line_follow_ctrl #(
        .N_SENS    (3),
        .CLK_HZ    (1000),
        .SRCH_L_MS (4),
        .SRCH_R_MS (8),
        .PWM_BITS  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IPS       (IPS),
        .sw_ON     (sw_ON),
        .speed     (speed),
        .IN        (IN),
        .EN        (EN),
        .lost      (lost),
        .searching (searching)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [3:0] in_v, input bit chk_en,
                            input logic [1:0] en_v, input logic lost_v, input logic srch_v);
        exp_t e;
        e.tag = tag; e.in_v = in_v; e.chk_en = chk_en;
        e.en_v = en_v; e.lost_v = lost_v; e.srch_v = srch_v;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        assert (sbq.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed=0 entries expected=>0");
        end
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        n_cmp++;
        assert (IN === e.in_v) else begin
            n_fail++;
            $error("FAIL %s.IN: observed=%b expected=%b", e.tag, IN, e.in_v);
        end
        n_cmp++;
        assert (lost === e.lost_v) else begin
            n_fail++;
            $error("FAIL %s.lost: observed=%b expected=%b", e.tag, lost, e.lost_v);
        end
        n_cmp++;
        assert (searching === e.srch_v) else begin
            n_fail++;
            $error("FAIL %s.searching: observed=%b expected=%b", e.tag, searching, e.srch_v);
        end
        if (e.chk_en) begin
            n_cmp++;
            assert (EN === e.en_v) else begin
                n_fail++;
                $error("FAIL %s.EN: observed=%b expected=%b", e.tag, EN, e.en_v);
            end
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic count_en_hi(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (EN == 2'b11) hi++;
        end
    endtask

    task automatic steer(input string tag, input logic [2:0] ips_v, input logic [3:0] code);
        IPS = ips_v;
        push_exp(tag, code, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        pop_check();
    endtask

    // Lose the line from TRACK: samples 3..6 first sweep, 7..14 second, then stopped
    task automatic sweep_seq(input string tag, input logic [3:0] first, input logic [3:0] second);
        IPS = 3'b111;
        repeat (2) @(negedge clk);
        for (int k = 3; k <= 16; k++) begin
            if (k <= 6)       push_exp({tag, "_first"}, first, 1'b0, 2'b00, 1'b0, 1'b1);
            else if (k <= 14) push_exp({tag, "_second"}, second, 1'b0, 2'b00, 1'b0, 1'b1);
            else              push_exp({tag, "_lost"}, C_STOP, 1'b1, 2'b00, 1'b1, 1'b0);
        end
        for (int k = 3; k <= 16; k++) begin
            @(negedge clk);
            pop_check();
        end
    endtask

    initial begin
        int hi;
        int found;
        logic prev;

        // Reset state
        rst_n = 1'b0; sw_ON = 1'b0; IPS = 3'b111; speed = 4'h5;
        repeat (2) @(negedge clk);
        push_exp("reset", C_STOP, 1'b1, 2'b00, 1'b0, 1'b0);
        pop_check();
        rst_n = 1'b1;

        // 1: enable on the line
        sw_ON = 1'b1; IPS = 3'b101;
        push_exp("start_fwd", C_FWD, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        pop_check();
        count_en_hi(15, hi);
        check_int("pwm_duty5_start", hi, 5);

        // 5: PWM duty extremes and glitch-free update
        speed = 4'h0;
        repeat (17) @(negedge clk);
        count_en_hi(15, hi);
        check_int("pwm_duty0", hi, 0);
        speed = 4'hF;
        repeat (17) @(negedge clk);
        count_en_hi(15, hi);
        check_int("pwm_dutyF", hi, 15);
        speed = 4'h5;
        repeat (17) @(negedge clk);
        count_en_hi(15, hi);
        check_int("pwm_duty5", hi, 5);
        found = 0;
        prev = EN[0];
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!prev && EN[0]) begin
                found = 1;
                break;
            end
            prev = EN[0];
        end
        check_int("pwm_edge_found", found, 1);
        repeat (2) @(negedge clk);
        speed = 4'hA;
        repeat (5) @(negedge clk);
        check_int("pwm_midperiod_old", int'(EN[0]), 0);
        repeat (15) @(negedge clk);
        check_int("pwm_midperiod_new", int'(EN[0]), 1);
        speed = 4'h5;

        // 2: steering priorities
        steer("steer_left", 3'b011, C_LEFT);
        steer("steer_right", 3'b110, C_RIGHT);
        steer("steer_centre_prio", 3'b000, C_FWD);
        steer("steer_left_prio", 3'b010, C_LEFT);

        // 3: full search to LOST
        sweep_seq("search", C_LEFT, C_RIGHT);

        // 4: recovery from LOST, reacquire in SRCH_R, reacquire on expiry cycle
        steer("lost_recover", 3'b101, C_FWD);
        IPS = 3'b111;
        repeat (8) @(negedge clk);
        IPS = 3'b101;
        push_exp("reacq_mid_srchr", C_RIGHT, 1'b0, 2'b00, 1'b0, 1'b1);
        push_exp("reacq_mid_track", C_FWD, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pop_check();
        @(negedge clk);
        pop_check();
        repeat (3) @(negedge clk);
        IPS = 3'b111;
        repeat (12) @(negedge clk);
        IPS = 3'b101;
        push_exp("reacq_expiry_srchr", C_RIGHT, 1'b0, 2'b00, 1'b0, 1'b1);
        push_exp("reacq_expiry_track", C_FWD, 1'b0, 2'b00, 1'b0, 1'b0);
        push_exp("reacq_expiry_hold", C_FWD, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pop_check();
        @(negedge clk);
        pop_check();
        @(negedge clk);
        pop_check();

        // Sweep order after the line was last seen on the right
        steer("right_last", 3'b110, C_RIGHT);
`ifdef SEARCH_LAST_SIDE_EN
        sweep_seq("lastside", C_RIGHT, C_LEFT);
`else
        sweep_seq("lastside", C_LEFT, C_RIGHT);
`endif
        steer("lastside_recover", 3'b101, C_FWD);

        // 6: switch off mid-SRCH_L
        IPS = 3'b111;
        repeat (4) @(negedge clk);
        sw_ON = 1'b0;
        push_exp("swoff_srchl", C_LEFT, 1'b0, 2'b00, 1'b0, 1'b1);
        push_exp("swoff_idle", C_STOP, 1'b1, 2'b00, 1'b0, 1'b0);
        push_exp("swoff_idle_hold", C_STOP, 1'b1, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pop_check();
        @(negedge clk);
        pop_check();
        @(negedge clk);
        pop_check();

        // 6: reset asserted mid-SRCH_R
        sw_ON = 1'b1;
        push_exp("rerun_srchl", C_LEFT, 1'b0, 2'b00, 1'b0, 1'b1);
        push_exp("rerun_srchr", C_RIGHT, 1'b0, 2'b00, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        pop_check();
        repeat (4) @(negedge clk);
        pop_check();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", C_STOP, 1'b1, 2'b00, 1'b0, 1'b0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        push_exp("post_reset_idle", C_STOP, 1'b1, 2'b00, 1'b0, 1'b0);
        push_exp("post_reset_idle2", C_STOP, 1'b1, 2'b00, 1'b0, 1'b0);
        push_exp("post_reset_track", C_STOP, 1'b0, 2'b00, 1'b0, 1'b0);
        push_exp("post_reset_srchl", C_LEFT, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pop_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
